// File: rtl/preg_free_list_if.sv
// -----------------------------------------------------------------------------
// preg_free_list_if
//
// Bundles the allocation and release signals between the rename/retire
// pipeline and the physical-register free list.
//
// Parameters:
//   NUM_PREGS  total physical registers (sets the PReg index width)
//   WIDTH      allocation lanes and release lanes per cycle
//
// Signals (the directions shown are as seen by the free list):
//   i_alloc_req   in   [WIDTH]        lane i wants a destination PReg
//   o_alloc_preg  out  [WIDTH] x PW   PReg granted to lane i, 0 when not granted
//   o_alloc_ok    out  1              every requesting lane was served
//   i_free_valid  in   [WIDTH]        lane i returns a PReg
//   i_free_preg   in   [WIDTH] x PW   returned PReg; 0 is ignored
//   o_free_count  out  CW             entries currently in the list
//   o_overflow    out  1              sticky: a push hit a full list
//   o_double_free out  1              sticky: a duplicate free was dropped
//
// Modports:
//   master  rename/retire side (drives requests and frees)
//   slave   the free list
// -----------------------------------------------------------------------------
interface preg_free_list_if #(
  parameter int NUM_PREGS = 128,
  parameter int WIDTH     = 2
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int CW = $clog2(NUM_PREGS + 1);

  logic [WIDTH-1:0] i_alloc_req;
  logic [PW-1:0]    o_alloc_preg [WIDTH];
  logic             o_alloc_ok;
  logic [WIDTH-1:0] i_free_valid;
  logic [PW-1:0]    i_free_preg  [WIDTH];
  logic [CW-1:0]    o_free_count;
  logic             o_overflow;
  logic             o_double_free;

  modport master (
    output i_alloc_req, i_free_valid, i_free_preg,
    input  o_alloc_preg, o_alloc_ok, o_free_count, o_overflow, o_double_free
  );

  modport slave (
    input  i_alloc_req, i_free_valid, i_free_preg,
    output o_alloc_preg, o_alloc_ok, o_free_count, o_overflow, o_double_free
  );
endinterface

// File: rtl/preg_free_list.sv
// -----------------------------------------------------------------------------
// preg_free_list
//
// Physical-register free list for the 2-wide rename/retire pipeline. It is a
// circular FIFO of PReg indices. Rename pops up to WIDTH entries per cycle,
// with all-or-nothing granting, and retire pushes up to WIDTH released PRegs
// per cycle.
//
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset, restores the post-boot free list
//   bus     preg_free_list_if.slave (allocation and release lanes, status)
//
// Optional build macro:
//   FREELIST_DUPCHECK_EN  tracks which PRegs sit in the list, drops duplicate
//                         frees and reports them on o_double_free. When this
//                         macro is undefined, o_double_free is tied to 0.
// -----------------------------------------------------------------------------
module preg_free_list #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32,
  parameter int WIDTH     = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  preg_free_list_if.slave     bus
);
  localparam int DEPTH     = NUM_PREGS - 1;
  localparam int PW        = $clog2(NUM_PREGS);
  localparam int CW        = $clog2(NUM_PREGS + 1);
  localparam int INIT_FREE = NUM_PREGS - NUM_AREGS;

  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow_q;

  logic [CW-1:0] nreq;
  logic [CW-1:0] npop;
  logic [CW-1:0] npush;
  logic [CW-1:0] space;
  logic [CW-1:0] offset;
  logic          grant;
  logic          overflow_hit;
  logic [PW-1:0] alloc_preg_c [WIDTH];
  logic [PW-1:0] push_preg_c  [WIDTH];

`ifdef FREELIST_DUPCHECK_EN
  logic [NUM_PREGS-1:0] in_list;
  logic                 double_free_q;
  logic                 dup_hit;
  logic                 is_dup;
`endif

  // DEPTH is not a power of two, so pointers wrap with an explicit compare
  // and subtract. Increments never exceed WIDTH, so one subtraction suffices.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p,
                                            input logic [CW-1:0] n);
    logic [CW:0] s;
    s = {{(CW+1-PW){1'b0}}, p} + {1'b0, n};
    if (s >= DEPTH_W) s = s - DEPTH_W;
    return s[PW-1:0];
  endfunction

  // Allocation: the request is granted only if every requesting lane can be
  // served from the current count. Freed PRegs do not bypass into the same
  // cycle. Granted lanes take consecutive entries from head in lane order.
  always_comb begin
    nreq   = '0;
    offset = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nreq = nreq + CW'(bus.i_alloc_req[i]);
    end
    grant = !i_rst && (nreq != '0) && (nreq <= count);
    npop  = grant ? nreq : '0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc_preg_c[i] = '0;
      if (grant && bus.i_alloc_req[i]) begin
        alloc_preg_c[i] = entries[ptr_add(head, offset)];
        offset          = offset + CW'(1);
      end
    end
  end

  // Release: valid nonzero PRegs are compacted in lane order. Space accounts
  // for this cycle's pops, so a full list can still accept a push alongside a
  // pop. Later lanes are dropped first when space runs out.
  always_comb begin
    space        = DEPTH_C - count + npop;
    npush        = '0;
    overflow_hit = 1'b0;
`ifdef FREELIST_DUPCHECK_EN
    dup_hit      = 1'b0;
    is_dup       = 1'b0;
`endif
    for (int j = 0; j < WIDTH; j++) begin
      push_preg_c[j] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.i_free_valid[i] && (bus.i_free_preg[i] != '0)) begin
`ifdef FREELIST_DUPCHECK_EN
        // A PReg already in the list, or one that repeats an earlier lane's
        // PReg, is a double free and is dropped before it can use space.
        is_dup = in_list[bus.i_free_preg[i]];
        for (int k = 0; k < i; k++) begin
          if (bus.i_free_valid[k] && (bus.i_free_preg[k] == bus.i_free_preg[i]))
            is_dup = 1'b1;
        end
        if (is_dup) dup_hit = 1'b1;
        else
`endif
        if (npush < space) begin
          for (int j = 0; j < WIDTH; j++) begin
            if (CW'(j) == npush) push_preg_c[j] = bus.i_free_preg[i];
          end
          npush = npush + CW'(1);
        end else begin
          overflow_hit = 1'b1;
        end
      end
    end
  end

  // FIFO state. Reset rebuilds the boot-time list: PRegs NUM_AREGS and above
  // are free, and the lower ones back the architectural registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        entries[k] <= (k < INIT_FREE) ? PW'(NUM_AREGS + k) : '0;
      end
      head       <= '0;
      tail       <= PW'(INIT_FREE);
      count      <= CW'(INIT_FREE);
      overflow_q <= 1'b0;
    end else begin
      for (int j = 0; j < WIDTH; j++) begin
        if (CW'(j) < npush) entries[ptr_add(tail, CW'(j))] <= push_preg_c[j];
      end
      head  <= ptr_add(head, npop);
      tail  <= ptr_add(tail, npush);
      count <= count - npop + npush;
      if (overflow_hit) overflow_q <= 1'b1;
    end
  end

`ifdef FREELIST_DUPCHECK_EN
  // Membership vector: clear popped PRegs, then set pushed ones. A pushed PReg
  // is never in the list already, so the two updates cannot collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        in_list[i] <= (i >= NUM_AREGS);
      end
      double_free_q <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (grant && bus.i_alloc_req[i]) in_list[alloc_preg_c[i]] <= 1'b0;
      end
      for (int j = 0; j < WIDTH; j++) begin
        if (CW'(j) < npush) in_list[push_preg_c[j]] <= 1'b1;
      end
      if (dup_hit) double_free_q <= 1'b1;
    end
  end

  assign bus.o_double_free = double_free_q;
`else
  assign bus.o_double_free = 1'b0;
`endif

  assign bus.o_alloc_preg = alloc_preg_c;
  assign bus.o_alloc_ok   = grant;
  assign bus.o_free_count = count;
  assign bus.o_overflow   = overflow_q;

endmodule

// File: tb/tb_preg_free_list.sv
// -----------------------------------------------------------------------------
// tb_preg_free_list
//
// Directed testbench for preg_free_list. It drives the bus interface with
// hand-computed vectors and compares the outputs against expected values.
// A small queue models the FIFO order while the list runs in steady state.
// Expectations follow FREELIST_DUPCHECK_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_preg_free_list;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  preg_free_list_if #(.NUM_PREGS(128), .WIDTH(2)) bus ();

  preg_free_list #(
    .NUM_PREGS(128),
    .NUM_AREGS(32),
    .WIDTH(2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int q[$];

  // Every comparison is counted here. A mismatch prints one report line.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs and let the combinational outputs settle.
  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic v0, input logic v1,
                               input int p0, input int p1);
    bus.i_alloc_req    = {r1, r0};
    bus.i_free_valid   = {v1, v0};
    bus.i_free_preg[0] = 7'(p0);
    bus.i_free_preg[1] = 7'(p1);
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    nextCycle();
    rst = 1'b0;
  endtask

  function automatic int seqVal(input int m);
    return 1 + ((11 + m) % 127);
  endfunction

  initial begin
    int a;
    int b;
    int e0;
    int e1;

    // Reset with requests and frees active: nothing is granted during reset.
    rst = 1'b1;
    applyStimulus(1, 1, 1, 1, 9, 10);
    nextCycle();
    applyStimulus(1, 1, 1, 1, 9, 10);
    checkOutput("rst ok", bus.o_alloc_ok, 0);
    checkOutput("rst p0", bus.o_alloc_preg[0], 0);
    checkOutput("rst p1", bus.o_alloc_preg[1], 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst count", bus.o_free_count, 96);
    checkOutput("rst ovf", bus.o_overflow, 0);
    checkOutput("rst dbl", bus.o_double_free, 0);
    checkOutput("idle ok", bus.o_alloc_ok, 0);

    // Both lanes request right after reset.
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("dual ok", bus.o_alloc_ok, 1);
    checkOutput("dual p0", bus.o_alloc_preg[0], 32);
    checkOutput("dual p1", bus.o_alloc_preg[1], 33);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("dual count", bus.o_free_count, 94);
    checkOutput("head2 p0", bus.o_alloc_preg[0], 34);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("head2 count", bus.o_free_count, 93);

    // A reset in mid-operation restores the list. Lane 1 alone takes the head.
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("lane1 ok", bus.o_alloc_ok, 1);
    checkOutput("lane1 p0", bus.o_alloc_preg[0], 0);
    checkOutput("lane1 p1", bus.o_alloc_preg[1], 32);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lane1 count", bus.o_free_count, 95);

    // Drain the list down to one entry, then test the all-or-nothing grant.
    doReset();
    for (int n = 0; n < 47; n++) begin
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput($sformatf("drain p0 %0d", n), bus.o_alloc_preg[0], 32 + 2*n);
      checkOutput($sformatf("drain p1 %0d", n), bus.o_alloc_preg[1], 33 + 2*n);
      nextCycle();
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("drain last", bus.o_alloc_preg[0], 126);
    nextCycle();
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("short count", bus.o_free_count, 1);
    checkOutput("short ok", bus.o_alloc_ok, 0);
    checkOutput("short p0", bus.o_alloc_preg[0], 0);
    checkOutput("short p1", bus.o_alloc_preg[1], 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("short hold", bus.o_free_count, 1);
    checkOutput("single ok", bus.o_alloc_ok, 1);
    checkOutput("single p0", bus.o_alloc_preg[0], 127);
    nextCycle();

    // Empty list: a free does not bypass to a request in the same cycle.
    // PReg 0 is never pushed.
    applyStimulus(1, 0, 1, 1, 5, 0);
    checkOutput("empty count", bus.o_free_count, 0);
    checkOutput("empty ok", bus.o_alloc_ok, 0);
    checkOutput("empty p0", bus.o_alloc_preg[0], 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("push5 count", bus.o_free_count, 1);
    checkOutput("push5 ok", bus.o_alloc_ok, 1);
    checkOutput("push5 p0", bus.o_alloc_preg[0], 5);
    nextCycle();
    applyStimulus(0, 0, 1, 0, 6, 9);
    nextCycle();
    applyStimulus(0, 0, 1, 1, 10, 11);
    checkOutput("invalid lane count", bus.o_free_count, 1);
    nextCycle();
    q = '{6, 10, 11};

    // Steady state: 200 frees and 200 allocations wrap both pointers.
    for (int n = 0; n < 100; n++) begin
      a  = seqVal(2*n);
      b  = seqVal(2*n + 1);
      e0 = q.pop_front();
      e1 = q.pop_front();
      applyStimulus(1, 1, 1, 1, a, b);
      checkOutput($sformatf("steady ok %0d", n), bus.o_alloc_ok, 1);
      checkOutput($sformatf("steady p0 %0d", n), bus.o_alloc_preg[0], e0);
      checkOutput($sformatf("steady p1 %0d", n), bus.o_alloc_preg[1], e1);
      q.push_back(a);
      q.push_back(b);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("steady count %0d", n), bus.o_free_count, 3);
    end

    // Fill to full. Lane 1 of the last push has no room, or is a duplicate.
    doReset();
    for (int n = 0; n < 15; n++) begin
      applyStimulus(0, 0, 1, 1, 2*n + 1, 2*n + 2);
      nextCycle();
    end
    applyStimulus(0, 0, 1, 1, 31, 1);
    checkOutput("fill count", bus.o_free_count, 126);
    nextCycle();
    applyStimulus(1, 0, 1, 0, 20, 0);
    checkOutput("full count", bus.o_free_count, 127);
    checkOutput("full p0", bus.o_alloc_preg[0], 32);
`ifdef FREELIST_DUPCHECK_EN
    checkOutput("full ovf", bus.o_overflow, 0);
    checkOutput("full dbl", bus.o_double_free, 1);
`else
    checkOutput("full ovf", bus.o_overflow, 1);
    checkOutput("full dbl", bus.o_double_free, 0);
`endif
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef FREELIST_DUPCHECK_EN
    checkOutput("pop push count", bus.o_free_count, 126);
    checkOutput("sticky ovf", bus.o_overflow, 0);
`else
    checkOutput("pop push count", bus.o_free_count, 127);
    checkOutput("sticky ovf", bus.o_overflow, 1);
`endif

    // Duplicate frees: a PReg already in the list, and the same PReg on both lanes.
    doReset();
    applyStimulus(0, 0, 1, 0, 40, 0);
    checkOutput("clr ovf", bus.o_overflow, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef FREELIST_DUPCHECK_EN
    checkOutput("dup40 count", bus.o_free_count, 96);
    checkOutput("dup40 dbl", bus.o_double_free, 1);
`else
    checkOutput("dup40 count", bus.o_free_count, 97);
    checkOutput("dup40 dbl", bus.o_double_free, 0);
`endif
    doReset();
    applyStimulus(0, 0, 1, 1, 7, 7);
    checkOutput("clr dbl", bus.o_double_free, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef FREELIST_DUPCHECK_EN
    checkOutput("dup77 count", bus.o_free_count, 97);
    checkOutput("dup77 dbl", bus.o_double_free, 1);
`else
    checkOutput("dup77 count", bus.o_free_count, 98);
    checkOutput("dup77 dbl", bus.o_double_free, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
